// File: rtl/item_spawn_sched.sv
// Item placement sequencer for the snake game: requests candidate positions, range-checks them,
// publishes the live item, and handles eat/grow/score. Optional item expiry via `ITEM_LIFETIME_EN.
`timescale 1ns/1ps
module item_spawn_sched #(
    parameter int GRID_W    = 80,
    parameter int GRID_H    = 60,
    parameter int TIMEOUT   = 1023,
    parameter int MAX_RETRY = 7,
`ifdef ITEM_LIFETIME_EN
    parameter int LIFETIME  = 4095,
`endif
    parameter int SCORE_W   = 10
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Start,
    input  logic               i_Eaten,
    input  logic               i_Gen_Done,
    input  logic [6:0]         i_Gen_x,
    input  logic [6:0]         i_Gen_y,
    output logic               o_Gen_Req,
    output logic [6:0]         o_Item_x,
    output logic [6:0]         o_Item_y,
    output logic               o_Item_valid,
    output logic               o_Grow,
    output logic [SCORE_W-1:0] o_Score,
    output logic               o_Fail
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE, S_FAIL} state_t;

    localparam logic [7:0] X_LIMIT    = 8'(GRID_W);
    localparam logic [7:0] Y_LIMIT    = 8'(GRID_H);
    localparam logic [9:0] TMO_MAX    = 10'(TIMEOUT);
    localparam logic [2:0] RETRY_LAST = 3'(MAX_RETRY - 1);

    state_t             state_q, state_d;
    logic [9:0]         tmo_q, tmo_d;
    logic [2:0]         retry_q, retry_d;
    logic               req_d, valid_d, grow_d, fail_d;
    logic [6:0]         x_d, y_d;
    logic [SCORE_W-1:0] score_d;
    logic               in_range;
`ifdef ITEM_LIFETIME_EN
    localparam logic [11:0] LIFE_MAX = 12'(LIFETIME);
    logic [11:0]        life_q, life_d;
`endif

    assign in_range = ({1'b0, i_Gen_x} < X_LIMIT) && ({1'b0, i_Gen_y} < Y_LIMIT);

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        retry_d = retry_q;
        req_d   = o_Gen_Req;
        x_d     = o_Item_x;
        y_d     = o_Item_y;
        valid_d = o_Item_valid;
        grow_d  = 1'b0;
        score_d = o_Score;
        fail_d  = o_Fail;
`ifdef ITEM_LIFETIME_EN
        life_d  = life_q;
`endif
        if (i_Start) begin
            state_d = S_WAIT;
            tmo_d   = '0;
            retry_d = '0;
            req_d   = 1'b1;
            valid_d = 1'b0;
            score_d = '0;
            fail_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_WAIT: begin
                    tmo_d = tmo_q + 10'd1;
                    req_d = 1'b1;
                    if (i_Gen_Done && in_range) begin
                        state_d = S_ACTIVE;
                        x_d     = i_Gen_x;
                        y_d     = i_Gen_y;
                        valid_d = 1'b1;
                        req_d   = 1'b0;
                        retry_d = '0;
                        tmo_d   = '0;
`ifdef ITEM_LIFETIME_EN
                        life_d  = '0;
`endif
                    end else if (i_Gen_Done || tmo_q == TMO_MAX) begin
                        // Dropping req for one cycle gives the generator a fresh request edge.
                        tmo_d   = '0;
                        req_d   = 1'b0;
                        retry_d = retry_q + 3'd1;
                        if (retry_q == RETRY_LAST) begin
                            state_d = S_FAIL;
                            fail_d  = 1'b1;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (i_Eaten) begin
                        state_d = S_WAIT;
                        grow_d  = 1'b1;
                        if (o_Score != '1) score_d = o_Score + 1'b1;
                        valid_d = 1'b0;
                        req_d   = 1'b1;
                        tmo_d   = '0;
                        retry_d = '0;
                    end
`ifdef ITEM_LIFETIME_EN
                    else if (life_q == LIFE_MAX) begin
                        state_d = S_WAIT;
                        valid_d = 1'b0;
                        req_d   = 1'b1;
                        tmo_d   = '0;
                        retry_d = '0;
                    end else begin
                        life_d = life_q + 12'd1;
                    end
`endif
                end
                S_FAIL: begin
                    req_d   = 1'b0;
                    valid_d = 1'b0;
                    fail_d  = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q      <= S_IDLE;
            tmo_q        <= '0;
            retry_q      <= '0;
            o_Gen_Req    <= 1'b0;
            o_Item_x     <= '0;
            o_Item_y     <= '0;
            o_Item_valid <= 1'b0;
            o_Grow       <= 1'b0;
            o_Score      <= '0;
            o_Fail       <= 1'b0;
`ifdef ITEM_LIFETIME_EN
            life_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            retry_q      <= retry_d;
            o_Gen_Req    <= req_d;
            o_Item_x     <= x_d;
            o_Item_y     <= y_d;
            o_Item_valid <= valid_d;
            o_Grow       <= grow_d;
            o_Score      <= score_d;
            o_Fail       <= fail_d;
`ifdef ITEM_LIFETIME_EN
            life_q       <= life_d;
`endif
        end
    end

endmodule
